// File: rtl/knn_ctrl.sv
// knn_ctrl: sequencing controller for the KNN distance datapath.
// Walks every test point against every data point. It drives the data-memory
// read strobe and indices, and issues en_dist/rst_dist to the distance core
// with a fixed 1-cycle memory latency. Between test points it handshakes with
// the K-nearest list block.
// Optional build macro KNN_CTRL_PERF_EN adds the perf_cycles_o/perf_stall_o
// saturating counters.
module knn_ctrl #(
   parameter  int NBR_TESTP = 4,
   parameter  int NBR_DATAP = 4,
   localparam int TP_W      = (NBR_TESTP > 1) ? $clog2(NBR_TESTP) : 1,
   localparam int DP_W      = (NBR_DATAP > 1) ? $clog2(NBR_DATAP) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic            list_rdy_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [TP_W-1:0] test_idx_o,
   output logic [DP_W-1:0] data_idx_o,
   output logic            rd_en_o,
   output logic            en_dist_o,
   output logic            rst_dist_o,
   output logic            last_dp_o,
`ifdef KNN_CTRL_PERF_EN
   output logic [31:0]     perf_cycles_o,
   output logic [31:0]     perf_stall_o,
`endif
   output logic            testp_done_o
);

   localparam logic [TP_W-1:0] TP_LAST = TP_W'(NBR_TESTP - 1);
   localparam logic [DP_W-1:0] DP_LAST = DP_W'(NBR_DATAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [TP_W-1:0] test_idx_q, test_idx_d;
   logic [DP_W-1:0] data_idx_q, data_idx_d;
   logic            busy_q, done_q, rd_en_q, rst_dist_q;
   logic            en_dist_q, last_dp_q;
   logic            abort_s;
   logic            testp_done_s;

   // abort only acts outside IDLE; in IDLE it is a no-op
   assign abort_s = abort_i & (state_q != S_IDLE);

   // Next-state, index update and test-point handshake
   always_comb begin
      state_d      = state_q;
      test_idx_d   = test_idx_q;
      data_idx_d   = {DP_W{1'b0}};
      testp_done_s = 1'b0;
      if (abort_s) begin
         state_d    = S_IDLE;
         test_idx_d = {TP_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               test_idx_d = {TP_W{1'b0}};
               if (start_i && !abort_i) begin
                  state_d = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_SETUP: begin
               state_d = S_RUN;
            end
            S_RUN: begin
               if (data_idx_q == DP_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  data_idx_d = data_idx_q + DP_W'(1);
               end
            end
            S_DRAIN: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (list_rdy_i) begin
                  testp_done_s = 1'b1;
                  if (test_idx_q == TP_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     test_idx_d = test_idx_q + TP_W'(1);
                     state_d    = S_SETUP;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DONE: begin
               test_idx_d = {TP_W{1'b0}};
               state_d    = S_IDLE;
            end
            default: begin
               test_idx_d = {TP_W{1'b0}};
               state_d    = S_IDLE;
            end
         endcase
      end
   end

   // State, indices and state-decoded strobes, registered from next state
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         test_idx_q <= {TP_W{1'b0}};
         data_idx_q <= {DP_W{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rst_dist_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         test_idx_q <= test_idx_d;
         data_idx_q <= data_idx_d;
         busy_q     <= (state_d == S_SETUP) || (state_d == S_RUN) ||
                       (state_d == S_DRAIN) || (state_d == S_WAIT);
         done_q     <= (state_d == S_DONE);
         rd_en_q    <= (state_d == S_RUN);
         rst_dist_q <= (state_d == S_SETUP);
      end
   end

   // Memory-latency pipeline: en_dist/last_dp trail rd_en by one cycle, squashed on abort
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         en_dist_q <= 1'b0;
         last_dp_q <= 1'b0;
      end else begin
         en_dist_q <= rd_en_q & ~abort_s;
         last_dp_q <= rd_en_q & (data_idx_q == DP_LAST) & ~abort_s;
      end
   end

`ifdef KNN_CTRL_PERF_EN
   logic [31:0] perf_cycles_q, perf_stall_q;

   // Saturating activity/stall counters, cleared when a run is accepted
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_cycles_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else if ((state_q == S_IDLE) && start_i && !abort_i) begin
         perf_cycles_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else begin
         if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
         end else begin
            perf_cycles_q <= perf_cycles_q;
         end
         if ((state_q == S_WAIT) && !list_rdy_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end else begin
            perf_stall_q <= perf_stall_q;
         end
      end
   end

   assign perf_cycles_o = perf_cycles_q;
   assign perf_stall_o  = perf_stall_q;
`endif

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign test_idx_o   = test_idx_q;
   assign data_idx_o   = data_idx_q;
   assign rd_en_o      = rd_en_q;
   assign rst_dist_o   = rst_dist_q;
   assign en_dist_o    = en_dist_q;
   assign last_dp_o    = last_dp_q;
   // The list accepts a test point in the same cycle list_rdy is seen
   assign testp_done_o = testp_done_s & rst_ni;

endmodule

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
- Sequencing controller for the KNN distance datapath.
- Walks every test point against every data point. Drives the data-memory read indices and read strobe, and issues the distance core's `en_dist`/`rst_dist` controls with a fixed 1-cycle memory latency.
- Handshakes with the downstream K-nearest list block between test points.
- Sits between the CPU-facing register/start logic and the distance core plus list block.

Parameters:
- NBR_TESTP, 4, number of test points per run (>=1)
- NBR_DATAP, 4, number of data points per test point (>=1)
- TP_W, max(1,clog2(NBR_TESTP)), test index width (derived, localparam)
- DP_W, max(1,clog2(NBR_DATAP)), data index width (derived, localparam)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel the run in progress
- list_rdy  in  1  list block can close the current test point
- busy  out  1  high from SETUP through WAIT_LIST
- done  out  1  1-cycle pulse at run completion
- test_idx  out  TP_W  current test point index
- data_idx  out  DP_W  data point index presented with rd_en
- rd_en  out  1  data-memory read strobe
- en_dist  out  1  distance core enable; rd_en delayed 1 cycle
- rst_dist  out  1  distance core clear, 1 cycle per test point
- last_dp  out  1  qualifies en_dist for the final data point
- testp_done  out  1  1-cycle pulse when the list accepts a test point

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE. All outputs 0, indices 0, internal pipeline register cleared. Reset has priority over everything.
- States: IDLE, SETUP, RUN, DRAIN, WAIT_LIST, DONE (one-hot or binary, implementer's choice).
- IDLE: all outputs 0.
  - start=1 -> SETUP, with test_idx=0.
- SETUP (1 cycle): rst_dist=1, data_idx=0 -> RUN.
- RUN: rd_en=1 every cycle, with data_idx=0..NBR_DATAP-1 in successive cycles.
  - At data_idx==NBR_DATAP-1 -> DRAIN.
  - data_idx never wraps past NBR_DATAP-1.
- en_dist pipeline: en_dist(t+1)=rd_en(t). last_dp(t+1)=rd_en(t) AND data_idx(t)==NBR_DATAP-1.
- DRAIN (1 cycle): carries the final en_dist/last_dp; rd_en=0 -> WAIT_LIST.
- WAIT_LIST: holds with all strobes 0 while list_rdy=0. In the cycle list_rdy=1:
  - testp_done=1.
  - If test_idx==NBR_TESTP-1 -> DONE.
  - Otherwise test_idx++ and -> SETUP.
- DONE (1 cycle): done=1, busy=0 -> IDLE. test_idx returns to 0 in IDLE.
- Timing with list_rdy tied high: each test point takes NBR_DATAP+3 cycles. If start is sampled at cycle 0, done=1 at cycle NBR_TESTP*(NBR_DATAP+3)+1. Defaults: cycle 29.
- start while busy or in DONE: ignored.
- abort=1 in any non-IDLE state: next state IDLE, all outputs 0, indices 0.
  - No done and no testp_done are issued.
  - Any en_dist still in the pipeline is squashed.
  - abort has priority over start and list_rdy. abort in IDLE has no effect.
- start and abort both high in IDLE: stay IDLE.
- NBR_DATAP=1: RUN lasts 1 cycle; en_dist and last_dp are both high in DRAIN.
- NBR_TESTP=1: TP_W=1; test_idx stays 0.
- Counters are sized exactly by TP_W/DP_W; comparisons use NBR_*-1 constants.

Optional Feature:
- Macro: KNN_CTRL_PERF_EN.
- Defined: adds output ports perf_cycles (32 bits) and perf_stall (32 bits).
  - Both clear on the cycle start is accepted.
  - perf_cycles increments every cycle busy=1.
  - perf_stall increments every WAIT_LIST cycle with list_rdy=0.
  - Both saturate at 2^32-1 and hold their values in IDLE.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Defaults, list_rdy=1, start pulse at cycle 0:
  - rd_en high in cycles 2-5, 9-12, 16-19, 23-26; en_dist one cycle later.
  - test_idx steps 0..3; testp_done at cycles 7, 14, 21, 28.
  - done only at cycle 29; busy high cycles 1-28.
- list_rdy held 0 for 5 cycles after the first DRAIN:
  - Controller stalls in WAIT_LIST with all strobes 0.
  - testp_done appears on the cycle list_rdy rises; done delayed by exactly 5 cycles (cycle 34).
  - With PERF_EN: perf_stall=5 and perf_cycles=33.
- abort asserted at cycle 10 (mid-RUN, second test point):
  - Next cycle busy=0, en_dist=0, indices 0.
  - No done and no further testp_done.
  - A new start then completes normally in 29 cycles.
- rst driven 0 at cycle 15, then released: all outputs 0 the following cycle; start is accepted afterwards.
- NBR_TESTP=1, NBR_DATAP=1:
  - rd_en at cycle 2 only.
  - en_dist and last_dp both high at cycle 3.
  - testp_done at cycle 4; done at cycle 5.
- start pulsed again at cycle 10 and during DONE: ignored; exactly one done per accepted start.
